// File: rtl/mem_access_stage.sv
// M-stage memory access unit: runs lw/sw as a req/ack handshake with a variable-latency
// data memory, stalls the front of the pipe meanwhile, and registers the writeback bundle.
module mem_access_stage #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m_valid,
    input  logic [4:0]        m_opcode,
    input  logic [4:0]        m_rd,
    input  logic [31:0]       m_addr,
    input  logic [31:0]       m_store_data,
    input  logic              m_writing,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic              w_valid,
    output logic [4:0]        w_rd,
    output logic [31:0]       w_data,
    output logic              w_we,
    output logic              mem_err
);

    localparam logic [4:0]       OP_LW    = 5'b01000;
    localparam logic [4:0]       OP_SW    = 5'b00111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_memReq;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [4:0]         r_rd;
    logic [31:0]        r_data;

    logic w_isLw;
    logic w_isSw;
    logic w_memOp;

    assign w_isLw  = (m_opcode == OP_LW);
    assign w_isSw  = (m_opcode == OP_SW);
    assign w_memOp = m_valid & (w_isLw | w_isSw);

    // DONE does not stall: the held instruction leaves M on the same edge W is loaded.
    assign stall = ((r_state == IDLE) & w_memOp) | (r_state == ACCESS);

    assign mem_req   = r_memReq;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_memReq <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= '0;
            r_data   <= '0;
            w_valid  <= 1'b0;
            w_rd     <= '0;
            w_data   <= '0;
            w_we     <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memOp) begin
                        r_we     <= w_isSw;
                        r_addr   <= m_addr[ADDR_W-1:0];
                        r_wdata  <= m_store_data;
                        r_rd     <= m_rd;
                        r_cnt    <= '0;
                        r_memReq <= 1'b1;
                        w_valid  <= 1'b0;
                        w_we     <= 1'b0;
                        r_state  <= ACCESS;
                    end else begin
                        w_valid <= m_valid;
                        w_rd    <= m_rd;
                        w_data  <= m_addr;
                        w_we    <= m_valid & m_writing & (m_rd != 5'd0);
                    end
                end
                ACCESS: begin
                    w_valid <= 1'b0;
                    w_we    <= 1'b0;
                    r_cnt   <= r_cnt + 1'b1;
                    // An ack arriving on the last allowed cycle still counts as success.
                    if (mem_ack) begin
                        r_data   <= mem_rdata;
                        r_memReq <= 1'b0;
                        r_state  <= DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        mem_err  <= 1'b1;
                        r_data   <= '0;
                        r_memReq <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    w_valid <= 1'b1;
                    w_rd    <= r_rd;
                    if (r_we) begin
                        w_data <= m_addr;
                        w_we   <= 1'b0;
                    end else begin
                        w_data <= r_data;
                        w_we   <= (r_rd != 5'd0);
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected writebacks, a monitor
// pops and compares them whenever W presents a valid instruction.
module tb_mem_access_stage;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 7;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_ADDI = 5'b00101;

    logic              clock;
    logic              reset;
    logic              m_valid;
    logic [4:0]        m_opcode;
    logic [4:0]        m_rd;
    logic [31:0]       m_addr;
    logic [31:0]       m_store_data;
    logic              m_writing;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              stall;
    logic              w_valid;
    logic [4:0]        w_rd;
    logic [31:0]       w_data;
    logic              w_we;
    logic              mem_err;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } wb_t;

    wb_t expQ[$];
    int  checks   = 0;
    int  failures = 0;

    mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .m_valid(m_valid), .m_opcode(m_opcode), .m_rd(m_rd), .m_addr(m_addr),
        .m_store_data(m_store_data), .m_writing(m_writing),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .w_valid(w_valid), .w_rd(w_rd), .w_data(w_data), .w_we(w_we),
        .mem_err(mem_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every valid W bundle must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && w_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_w_valid", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = expQ.pop_front();
                checkOutput("w_rd", {27'd0, w_rd}, {27'd0, e.rd});
                checkOutput("w_data", w_data, e.data);
                checkOutput("w_we", {31'd0, w_we}, {31'd0, e.we});
            end
        end
    end

    task automatic pushExp(input logic [4:0] rd, input logic [31:0] data, input logic we);
        wb_t e;
        e.rd = rd;
        e.data = data;
        e.we = we;
        expQ.push_back(e);
    endtask

    task automatic driveIdle();
        m_valid = 1'b0;
        m_opcode = 5'd0;
        m_rd = 5'd0;
        m_addr = 32'd0;
        m_store_data = 32'd0;
        m_writing = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
    endtask

    // Drives a non-memory op for one cycle; the writeback shows up on the next edge.
    task automatic applyStimulus(input logic valid, input logic [4:0] op, input logic [4:0] rd,
                                 input logic [31:0] addr, input logic writing, input logic ack);
        @(negedge clock);
        m_valid = valid;
        m_opcode = op;
        m_rd = rd;
        m_addr = addr;
        m_writing = writing;
        mem_ack = ack;
        #1;
        checkOutput("stall_nonmem", {31'd0, stall}, 32'd0);
        if (valid) pushExp(rd, addr, writing && (rd != 5'd0));
        @(negedge clock);
        driveIdle();
        #1;
        checkOutput("mem_req_nonmem", {31'd0, mem_req}, 32'd0);
    endtask

    // Runs a lw/sw; ackAfter = ACCESS cycle in which ack is given (0 = never).
    task automatic runMemOp(input logic isStore, input logic [4:0] rd, input logic [31:0] addr,
                            input logic [31:0] sdata, input int ackAfter, input logic [31:0] rdata,
                            input int expStall, input int expReq, input logic [31:0] expData);
        int stallCycles = 0;
        int reqCycles = 0;
        int guard = 0;
        @(negedge clock);
        m_valid = 1'b1;
        m_opcode = isStore ? OP_SW : OP_LW;
        m_rd = rd;
        m_addr = addr;
        m_store_data = sdata;
        m_writing = !isStore;
        #1;
        while (stall === 1'b1 && guard < 100) begin
            stallCycles++;
            @(negedge clock);
            guard++;
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                reqCycles++;
                if (reqCycles == 1) begin
                    checkOutput("mem_addr", {20'd0, mem_addr}, addr & 32'h0000_0FFF);
                    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, isStore});
                    if (isStore) checkOutput("mem_wdata", mem_wdata, sdata);
                end
                if (reqCycles == ackAfter) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
            end
            #1;
        end
        if (guard >= 100) checkOutput("stall_timeout", 32'd1, 32'd0);
        checkOutput("stall_cycles", stallCycles, expStall);
        checkOutput("req_cycles", reqCycles, expReq);
        pushExp(rd, expData, !isStore && (rd != 5'd0));
        @(negedge clock);
        driveIdle();
    endtask

    initial begin
        driveIdle();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("reset_w_valid", {31'd0, w_valid}, 32'd0);
        checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        checkOutput("reset_mem_err", {31'd0, mem_err}, 32'd0);
        reset = 1'b0;

        // addi rd=3 result 5, with a stray ack that must be ignored
        applyStimulus(1'b1, OP_ADDI, 5'd3, 32'd5, 1'b1, 1'b1);
        applyStimulus(1'b1, OP_ADDI, 5'd0, 32'h99, 1'b1, 1'b0);
        applyStimulus(1'b1, OP_ADDI, 5'd7, 32'hABCD_0123, 1'b0, 1'b0);
        // invalid lw is a bubble: no stall, no request
        applyStimulus(1'b0, OP_LW, 5'd4, 32'h10, 1'b1, 1'b0);

        runMemOp(1'b0, 5'd4, 32'h10, 32'd0, 3, 32'hDEAD, 4, 3, 32'hDEAD);
        runMemOp(1'b1, 5'd5, 32'h20, 32'd7, 1, 32'h5555, 2, 1, 32'h20);
        runMemOp(1'b0, 5'd0, 32'h30, 32'd0, 2, 32'h1234, 3, 2, 32'h1234);
        checkOutput("err_before_timeout", {31'd0, mem_err}, 32'd0);
        runMemOp(1'b0, 5'd9, 32'h44, 32'd0, 0, 32'hFFFF, 5, 4, 32'd0);
        checkOutput("err_after_timeout", {31'd0, mem_err}, 32'd1);
        applyStimulus(1'b1, OP_ADDI, 5'd2, 32'd42, 1'b1, 1'b0);
        checkOutput("err_sticky", {31'd0, mem_err}, 32'd1);

        // reset in the middle of an access
        @(negedge clock);
        m_valid = 1'b1;
        m_opcode = OP_LW;
        m_rd = 5'd6;
        m_addr = 32'h50;
        m_writing = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("mid_access_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        driveIdle();
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_w_valid", {31'd0, w_valid}, 32'd0);
        checkOutput("rst_w_rd", {27'd0, w_rd}, 32'd0);
        checkOutput("rst_w_data", w_data, 32'd0);
        checkOutput("rst_w_we", {31'd0, w_we}, 32'd0);
        checkOutput("rst_mem_err", {31'd0, mem_err}, 32'd0);

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
